// File: rtl/gate_arbiter_pkg.sv
// Shared opcode constants and FSM encoding for the gate arbiter.
// GATE_ARBITER_XOR_EN enables the XOR opcode in gate_unit.
package gate_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int ID_W  = 3;
  localparam int CNT_W = 16;

endpackage

// File: rtl/gate_arbiter_gate_unit.sv
// Combinational bitwise datapath: AND / OR / XOR of two operands.
// XOR is produced only when GATE_ARBITER_XOR_EN is defined; otherwise opcode 10 yields 0.
module gate_unit
  import gate_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
`ifdef GATE_ARBITER_XOR_EN
      OP_XOR: y = a ^ b;
`else
      OP_XOR: y = '0;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin arbiter feeding a single bitwise gate unit, one transaction in flight.
// Build option: GATE_ARBITER_XOR_EN enables the XOR opcode.
module gate_arbiter
  import gate_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count,
  output state_t                   state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both
  // high; ready never depends on the same-cycle ready of the other side.
  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, grant_id, hi_id, lo_id, id_q, rsp_id_q;
  logic              hi_any, lo_any, accept, rsp_fire;
  logic [1:0]        sel_op, op_q;
  logic [WIDTH-1:0]  sel_a, sel_b, a_q, b_q, gate_y, rsp_data_q;
  logic [CNT_W-1:0]  op_count_q;

  // Lowest valid index at/above the pointer wins; otherwise wrap to the lowest valid.
  always_comb begin
    hi_any = 1'b0;
    hi_id  = '0;
    lo_any = 1'b0;
    lo_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_any = 1'b1;
        lo_id  = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          hi_any = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
    grant_id = hi_any ? hi_id : lo_id;
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_op = req_op[i*2 +: 2];
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  gate_unit #(.WIDTH(WIDTH)) u_gate (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (gate_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state_q == ST_IDLE) && lo_any && !rst;
    rsp_valid = (state_q == ST_RESP);
    rsp_fire  = rsp_valid && rsp_ready;
    busy      = (state_q != ST_IDLE);
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant_id == ID_W'(i));
    end
  end

  // Operands are captured at accept so later input changes cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= grant_id;
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= gate_y;
        rsp_id_q   <= id_q;
      end
      if (rsp_fire) begin
        rr_ptr_q   <= (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter: transaction-level model plus directed scenarios.
// Expected XOR behaviour follows GATE_ARBITER_XOR_EN.
module tb_gate_arbiter;
  import gate_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
`ifdef GATE_ARBITER_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0;
  logic [W*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [15:0]    op_count;
  state_t         state_dbg;

  gate_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gate_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    if (op == 2'b00) return a & b;
    if (op == 2'b01) return a | b;
    if (op == 2'b10 && XOR_EN) return a ^ b;
    return '0;
  endfunction

  // transaction model: who is granted, when the response appears, what it holds
  bit              m_busy = 1'b0;
  int              m_age = 0;
  int              m_rr = 0;
  logic [15:0]     m_cnt = '0;
  logic [3+W-1:0]  exp_q[$];

  always @(negedge clk) begin : monitor
    int g;
    int k;
    logic [N-1:0] exp_rdy;
    bit exp_rv;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      m_busy = 1'b0;
      m_age  = 0;
      m_rr   = 0;
      m_cnt  = '0;
      exp_q.delete();
    end else begin
      g = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (g < 0 && req_valid[k]) g = k;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_rv = m_busy && (m_age >= 1);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("op_count", 32'(op_count), 32'(m_cnt));
      if (exp_rv) begin
        chk("rsp_id", 32'(rsp_id), 32'(exp_q[0][3+W-1:W]));
        chk("rsp_data", 32'(rsp_data), 32'(exp_q[0][W-1:0]));
      end
      if (!m_busy) begin
        if (g >= 0) begin
          exp_q.push_back({3'(g), gate_model(req_op[g*2 +: 2], req_a[g*W +: W], req_b[g*W +: W])});
          m_busy = 1'b1;
          m_age  = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (rsp_ready) begin
        m_rr   = (int'(exp_q[0][3+W-1:W]) + 1) % N;
        m_cnt  = m_cnt + 16'd1;
        m_busy = 1'b0;
        void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic scen_basic();
    do_reset();
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_op_count", 32'(op_count), 32'(0));
    chk("reset_rsp_data", 32'(rsp_data), 32'(0));
    chk("reset_rsp_id", 32'(rsp_id), 32'(0));
    chk("reset_state", 32'(state_dbg), 32'(0));
    step();
    req_valid = 4'b0010;
    req_op[3:2] = 2'b00;
    req_a[15:8] = 8'hF0;
    req_b[15:8] = 8'h3C;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("basic_grant", 32'(req_ready), 32'(4'b0010));
    step();
    req_valid = '0;
    req_op = 8'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    @(negedge clk);
    chk("basic_exec_no_valid", 32'(rsp_valid), 32'(0));
    step();
    @(negedge clk);
    chk("basic_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("basic_rsp_data", 32'(rsp_data), 32'(8'h30));
    chk("basic_rsp_id", 32'(rsp_id), 32'(1));
    step();
    @(negedge clk);
    chk("basic_count", 32'(op_count), 32'(1));
    chk("basic_idle", 32'(busy), 32'(0));
  endtask

  task automatic scen_rr();
    logic [N-1:0] grants[$];
    logic [N-1:0] exp_g[5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_op = 8'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (req_ready != '0) grants.push_back(req_ready);
      step();
    end
    @(negedge clk);
    chk("rr_count5", 32'(op_count), 32'(5));
    chk("rr_num_grants", 32'(grants.size()), 32'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) chk("rr_order", 32'(grants[i]), 32'(exp_g[i]));
    end
    req_valid = '0;
    repeat (3) step();
  endtask

  task automatic scen_stall();
    do_reset();
    req_valid = 4'b0100;
    req_op[5:4] = 2'b01;
    req_a[23:16] = 8'h12;
    req_b[23:16] = 8'h40;
    rsp_ready = 1'b0;
    step();
    req_valid = 4'hF;
    req_a = $urandom;
    req_b = $urandom;
    step();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'(1));
      chk("stall_data", 32'(rsp_data), 32'(8'h52));
      chk("stall_id", 32'(rsp_id), 32'(2));
      chk("stall_ready", 32'(req_ready), 32'(0));
      chk("stall_busy", 32'(busy), 32'(1));
      step();
    end
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("stall_done_busy", 32'(busy), 32'(0));
    chk("stall_done_count", 32'(op_count), 32'(1));
  endtask

  task automatic scen_xor();
    do_reset();
    req_valid = 4'b0001;
    req_op[1:0] = 2'b10;
    req_a[7:0] = 8'hAA;
    req_b[7:0] = 8'hFF;
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    chk("xor_data", 32'(rsp_data), XOR_EN ? 32'h55 : 32'h00);
    step();
  endtask

  task automatic scen_rst_exec();
    do_reset();
    req_valid = 4'b0010;
    req_op[3:2] = 2'b01;
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rstx_pre_count", 32'(op_count), 32'(1));
    req_valid = 4'b1000;
    step();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("rstx_in_exec", 32'(busy), 32'(1));
    step();
    rst = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rstx_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rstx_busy", 32'(busy), 32'(0));
    chk("rstx_count", 32'(op_count), 32'(0));
    chk("rstx_ptr_grant", 32'(req_ready), 32'(4'b0001));
    step();
    req_valid = '0;
    repeat (3) step();
  endtask

  task automatic scen_wrap();
    do_reset();
    force dut.op_count_q = 16'hFFFD;
    release dut.op_count_q;
    m_cnt = 16'hFFFD;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    req_op = 8'($urandom);
    req_a = $urandom;
    req_b = $urandom;
    repeat (9) step();
    @(negedge clk);
    chk("wrap_zero", 32'(op_count), 32'(0));
    repeat (3) step();
    @(negedge clk);
    chk("wrap_one", 32'(op_count), 32'(1));
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = 4'($urandom_range(0, 15));
      req_op    = 8'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    step();
    scen_basic();
    scen_rr();
    scen_stall();
    scen_xor();
    scen_rst_exec();
    scen_wrap();
    random_phase(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
